// File: rtl/affine_ctrl_pkg.sv
// Shared types for the affine schedule controller.
//   NUM_DIMS    loop-nest depth; index 0 is the outermost level
//   CTR_W       width of each iteration variable and extent field
//   TIME_W      width of the cycle counter, offset, strides and schedule times
//   sched_cfg_t schedule configuration bundle (offset, per-level extent and stride)
package affine_ctrl_pkg;

    localparam int NUM_DIMS = 3;
    localparam int CTR_W    = 16;
    localparam int TIME_W   = 32;

    typedef logic [CTR_W-1:0]  ctr_t;
    typedef logic [TIME_W-1:0] time_t;

    typedef ctr_t  [NUM_DIMS-1:0] ctr_vec_t;
    typedef time_t [NUM_DIMS-1:0] time_vec_t;

    typedef struct packed {
        time_t    offset;
        ctr_vec_t extent;
        time_vec_t stride;
    } sched_cfg_t;

endpackage

// File: rtl/affine_schedule_controller_if.sv
// Port bundle between the schedule config / buffer side and the controller.
//   flush     synchronous restart of the schedule state
//   en        global advance enable
//   cfg       schedule configuration (sampled only on rst or flush)
//   valid     fire strobe towards the buffer wen/ren
//   ctrl_vars iteration vector towards the buffer address logic
//   done      sticky, set once the final iteration has fired
// master: drives flush/en/cfg and observes the outputs; slave: the controller.
interface affine_schedule_controller_if;
    import affine_ctrl_pkg::*;

    logic       flush;
    logic       en;
    sched_cfg_t cfg;
    logic       valid;
    ctr_vec_t   ctrl_vars;
    logic       done;

    modport master (
        output flush, en, cfg,
        input  valid, ctrl_vars, done
    );

    modport slave (
        input  flush, en, cfg,
        output valid, ctrl_vars, done
    );

endinterface

// File: rtl/affine_ctrl_level.sv
// One level of the affine loop nest: holds the iteration variable and the
// schedule time of (outer vars, this var, inner vars all zero).
//   clk          clock
//   restart      synchronous restart (rst or flush)
//   fire         an iteration fired and the nest is not yet exhausted
//   carry_in     every inner level is saturated
//   extent       trip count minus 1 for this level
//   restart_time schedule offset loaded on restart
//   t            new time chosen by the advancing level
//   sat          variable has reached its extent
//   ctr          current variable value
//   lvl_time     schedule time at which this level's current value began
module affine_ctrl_level
    import affine_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  restart,
    input  logic  fire,
    input  logic  carry_in,
    input  ctr_t  extent,
    input  time_t restart_time,
    input  time_t t,
    output logic  sat,
    output ctr_t  ctr,
    output time_t lvl_time
);

    assign sat = (ctr >= extent);

    // With carry_in high this level is either the advancing level k
    // (not saturated) or one of the inner levels that wrap back to 0.
    always_ff @(posedge clk) begin
        if (restart) begin
            ctr      <= '0;
            lvl_time <= restart_time;
        end else if (fire && carry_in) begin
            ctr      <= sat ? '0 : ctr + ctr_t'(1);
            lvl_time <= t;
        end
    end

endmodule

// File: rtl/affine_schedule_controller.sv
// Drives wen/ren and ctrl_vars for one unified-buffer port by walking an
// affine loop nest: each iteration fires when the free-running cycle count
// reaches offset + sum(stride[i] * var[i]), computed incrementally.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  slave side of affine_schedule_controller_if
module affine_schedule_controller
    import affine_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    affine_schedule_controller_if.slave   bus
);

    logic      restart;
    time_t     cyc;
    time_t     next_time;
    logic      done_q;
    ctr_vec_t  shadow_extent;
    time_vec_t shadow_stride;

    logic [NUM_DIMS-1:0] sat;
    logic [NUM_DIMS-1:0] carry;
    ctr_vec_t            vars;
    time_vec_t           lvl_time;
    time_t               t_next;
    logic                all_sat;
    logic                valid;
    logic                advance;

    assign restart = rst | bus.flush;

    // carry[i]: every level inside i is saturated
    assign carry[NUM_DIMS-1] = 1'b1;
    for (genvar i = 0; i < NUM_DIMS-1; i++) begin : g_carry
        assign carry[i] = carry[i+1] & sat[i+1];
    end

    assign all_sat = carry[0] & sat[0];

    // Priority encoder: the innermost unsaturated level wins because it is
    // assigned last. The default only matters when all levels are
    // saturated, and then no level consumes t_next.
    always_comb begin
        t_next = lvl_time[NUM_DIMS-1] + shadow_stride[NUM_DIMS-1];
        for (int i = 0; i < NUM_DIMS; i++) begin
            if (!sat[i]) begin
                t_next = lvl_time[i] + shadow_stride[i];
            end
        end
    end

    // Gating with restart suppresses the pulse in the abort cycle itself.
    assign valid   = bus.en && !done_q && !restart && (cyc >= next_time);
    assign advance = valid && !all_sat;

    for (genvar i = 0; i < NUM_DIMS; i++) begin : g_lvl
        affine_ctrl_level u_lvl (
            .clk          (clk),
            .restart      (restart),
            .fire         (advance),
            .carry_in     (carry[i]),
            .extent       (shadow_extent[i]),
            .restart_time (bus.cfg.offset),
            .t            (t_next),
            .sat          (sat[i]),
            .ctr          (vars[i]),
            .lvl_time     (lvl_time[i])
        );
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            cyc           <= '0;
            next_time     <= bus.cfg.offset;
            done_q        <= 1'b0;
            shadow_extent <= bus.cfg.extent;
            shadow_stride <= bus.cfg.stride;
        end else if (bus.en) begin
            cyc <= cyc + time_t'(1);
            if (valid) begin
                if (all_sat) begin
                    done_q <= 1'b1;
                end else begin
                    next_time <= t_next;
                end
            end
        end
    end

    assign bus.valid     = valid;
    assign bus.ctrl_vars = vars;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_affine_schedule_controller.sv
module tb_affine_schedule_controller;
    import affine_ctrl_pkg::*;

    typedef struct {
        int unsigned cyc;
        ctr_vec_t    vars;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    affine_schedule_controller_if bus ();

    affine_schedule_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned tb_cyc   = 0;
    int          pulses   = 0;
    bit          just_restarted = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive a new config and build the expected firing list from first principles.
    task automatic load(input int unsigned off,
                        input int unsigned e0, input int unsigned e1, input int unsigned e2,
                        input int unsigned s0, input int unsigned s1, input int unsigned s2);
        int unsigned prev;
        int unsigned t;
        int unsigned fc;
        bit          first;
        exp_t        e;
        bus.cfg.offset    = time_t'(off);
        bus.cfg.extent[0] = ctr_t'(e0);
        bus.cfg.extent[1] = ctr_t'(e1);
        bus.cfg.extent[2] = ctr_t'(e2);
        bus.cfg.stride[0] = time_t'(s0);
        bus.cfg.stride[1] = time_t'(s1);
        bus.cfg.stride[2] = time_t'(s2);
        sb.delete();
        pulses = 0;
        first  = 1;
        prev   = 0;
        for (int a = 0; a <= int'(e0); a++) begin
            for (int b = 0; b <= int'(e1); b++) begin
                for (int c = 0; c <= int'(e2); c++) begin
                    t  = off + int'(a) * s0 + int'(b) * s1 + int'(c) * s2;
                    fc = (first || t > prev + 1) ? t : prev + 1;
                    first = 0;
                    prev  = fc;
                    e.cyc     = fc;
                    e.vars[0] = ctr_t'(a);
                    e.vars[1] = ctr_t'(b);
                    e.vars[2] = ctr_t'(c);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input logic en_v, input logic fl_v, input logic rs_v);
        exp_t e;
        bus.en    = en_v;
        bus.flush = fl_v;
        rst       = rs_v;
        @(negedge clk);
        if (fl_v || rs_v) begin
            chk("restart_valid", 64'(bus.valid), 64'(0));
        end else begin
            if (just_restarted) begin
                chk("restart_vars", 64'(bus.ctrl_vars), 64'(0));
                just_restarted = 0;
            end
            chk("done", 64'(bus.done), 64'(sb.size() == 0));
            if (!en_v) begin
                chk("stall_valid", 64'(bus.valid), 64'(0));
            end else if (bus.valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    chk("extra_pulse", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("fire_cyc", 64'(tb_cyc), 64'(e.cyc));
                    chk("fire_vars", 64'(bus.ctrl_vars), 64'(e.vars));
                end
            end
        end
        @(posedge clk);
        #1;
        if (fl_v || rs_v) begin
            tb_cyc = 0;
            just_restarted = 1;
        end else if (en_v) begin
            tb_cyc++;
        end
    endtask

    task automatic finish_case(input string tag, input int exp_pulses);
        chk({tag, "_left"}, 64'(sb.size()), 64'(0));
        chk({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        chk({tag, "_done"}, 64'(bus.done), 64'(1));
    endtask

    initial begin
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.flush = 1'b0;
        bus.cfg   = '0;

        // basic
        load(5, 0, 1, 3, 0, 8, 1);
        step(0, 0, 1);
        repeat (25) step(1, 0, 0);
        finish_case("basic", 8);

        // stall: en low during cycles 6..9 after reset release
        load(5, 0, 1, 3, 0, 8, 1);
        step(0, 0, 1);
        for (int c = 0; c < 30; c++) step(!(c >= 6 && c <= 9), 0, 0);
        finish_case("stall", 8);

        // flush at cycle 14 with a new offset
        load(5, 0, 1, 3, 0, 8, 1);
        step(0, 0, 1);
        repeat (14) step(1, 0, 0);
        load(2, 0, 1, 3, 0, 8, 1);
        step(1, 1, 0);
        repeat (25) step(1, 0, 0);
        finish_case("flush", 8);

        // catch-up: inner span exceeds outer stride
        load(0, 0, 1, 2, 0, 1, 1);
        step(0, 0, 1);
        repeat (15) step(1, 0, 0);
        finish_case("catchup", 6);

        // degenerate: single iteration, then done held
        load(3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1);
        repeat (105) step(1, 0, 0);
        finish_case("degen", 1);

        // reset mid-run at cycle 7
        load(5, 0, 1, 3, 0, 8, 1);
        step(0, 0, 1);
        repeat (7) step(1, 0, 0);
        load(5, 0, 1, 3, 0, 8, 1);
        step(1, 0, 1);
        repeat (25) step(1, 0, 0);
        finish_case("midrst", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/affine_schedule_controller.md
Name: affine_schedule_controller

Overview:
- Drives the control side of a unified-buffer port: the `*_wen`/`*_ren` strobe and the `*_ctrl_vars` iteration vector that the buffer's address logic consumes.
- Walks an affine loop nest of up to NUM_DIMS levels.
- Fires one iteration whenever the free-running cycle count reaches that iteration's scheduled time: offset + sum(stride[i]*var[i]).
- One instance per buffer port, sitting between the top-level schedule config and the buffer.

Parameters:
- NUM_DIMS, 3, loop-nest depth; ctrl_vars[0] is the outermost level, ctrl_vars[NUM_DIMS-1] the innermost.
- CTR_W, 16, width of each ctrl_vars element and each extent field.
- TIME_W, 32, width of the cycle counter, offset, strides and schedule times.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous restart: same effect as rst, but only for the schedule state.
- en  in  1  global advance enable. When low, the cycle counter and all state hold.
- cfg_offset  in  TIME_W  schedule time of iteration (0,...,0).
- cfg_extent  in  NUM_DIMS x CTR_W  per-level trip count minus 1.
- cfg_stride  in  NUM_DIMS x TIME_W  per-level time stride in cycles.
- valid  out  1  fire strobe; connects to the buffer's wen or ren.
- ctrl_vars  out  NUM_DIMS x CTR_W  current iteration vector; connects to the buffer's ctrl_vars.
- done  out  1  sticky; set once the last iteration has fired.

Behaviour:
- Reset: rst or flush (synchronous, sampled at posedge) sets:
  - cyc=0, ctrl_vars all 0, valid=0, done=0;
  - lvl_time[i]=cfg_offset for all i, next_time=cfg_offset;
  - latches cfg_* into internal shadow registers.
- Config inputs are ignored at all other times. rst and flush are equivalent inside this block.
- rst or flush asserted mid-run aborts immediately; no further valid pulses until the new schedule's time is reached.
- Counting: cyc increments by 1 on every cycle with en=1, rst=0, flush=0. It wraps modulo 2^TIME_W; wrap is out of scope.
- Firing:
  - valid = en && !done && (cyc >= next_time). It is combinational from registers, so the buffer sees valid and ctrl_vars in the same cycle.
  - The >= compare means a schedule whose stride is smaller than the inner span catches up. It then fires on consecutive cycles, at most one iteration per cycle, and never drops an iteration.
- ctrl_vars always shows the iteration that will fire on the next valid. It changes only at the posedge after a fire.
- Advance on a fire:
  - k = innermost level with var[k] < extent[k].
  - var[k]++ and var[j]=0 for all j>k.
  - t = lvl_time[k] + stride[k]; set lvl_time[j]=t for j>=k, next_time=t.
  - No multipliers anywhere. Stride additions wrap at TIME_W.
- Last iteration: if no such k exists (all vars at extent), then on that fire done<=1 and ctrl_vars holds the final vector. valid stays 0 until rst or flush.
- Extent 0 at a level means that level always holds 0. All extents 0 gives a single fire at cfg_offset.
- en=0: valid=0 and nothing advances, even if cyc >= next_time. Firing resumes on the first en=1 cycle.

Decomposition:
- Package affine_ctrl_pkg:
  - CTR_W and TIME_W localparams;
  - typedefs ctr_t (logic [CTR_W-1:0]) and time_t (logic [TIME_W-1:0]);
  - packed config struct {time_t offset; ctr_t extent[NUM_DIMS]; time_t stride[NUM_DIMS]}.
- Sub-module affine_ctrl_level, one per level:
  - holds var and lvl_time;
  - inputs: carry_in (all inner levels saturated), fire, restart, shared t;
  - outputs: saturated flag, var.
- The top level holds cyc, next_time, done, and a priority encoder for k.

Test Plan:
- Basic (NUM_DIMS=3, extent={0,1,3}, stride={0,8,1}, offset=5, en=1):
  - valid at cycles 5,6,7,8 and 13,14,15,16;
  - ctrl_vars (0,0,0..3) then (0,1,0..3);
  - done=1 from cycle 17; exactly 8 pulses total.
- Stall: same config, en=0 during cycles 6-9 → cycle counting and firing freeze; firings still follow the same order, and the total is still 8 pulses.
- Flush: flush at cycle 14 of the basic run with offset changed to 2 → no pulse at 14, ctrl_vars=0 and done=0 at cycle 15, first new pulse 3 cycles later.
- Catch-up: extent={0,1,2}, stride={0,1,1}, offset=0 → 6 pulses on 6 consecutive cycles 0-5, vars in lexicographic order.
- Degenerate: all extents 0, offset=3 → single pulse at cycle 3 with ctrl_vars=(0,0,0), then done=1 held for 100 cycles with no further valid.
- Reset mid-run: rst at cycle 7 of the basic run → valid=0, ctrl_vars=0 and done=0 on the next cycle, and the schedule replays from cycle 5 relative to reset release.
